// File: rtl/cpu_clk_ctrl.sv
// Run/step controller: divides Clkin into a one-cycle CpuEn for run, single CpuEn per step press, latches Halt.
// Latency: CpuEn one cycle after the tick/step rise; first run CpuEn div cycles after entering RUN.
// Backpressure: none; Halt overrides Mode, ticks and steps, and DivLoad restarts the run count.
module cpu_clk_ctrl #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DESIRE_FREQ = 1,
    parameter int CNT_W       = 27
) (
    input  logic             Clkin,
    input  logic             Rst,
    input  logic [1:0]       Mode,
    input  logic             StepReq,
    input  logic             Halt,
    input  logic             DivLoad,
    input  logic [CNT_W-1:0] DivVal,
    output logic             CpuEn,
    output logic             Clkout,
    output logic [1:0]       State
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(CLK_FREQ / DESIRE_FREQ);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic [1:0]       state_nxt;
    logic             at_end;
    logic             tick;
    logic             step_fire;

    assign at_end = (cnt == div - ONE);

    // A tick needs the run mode to still be selected and no halt or reload this cycle.
    assign tick = (State == S_RUN) && at_end && !DivLoad && !Halt && (Mode == S_RUN);

    assign step_fire = (State == S_STEP) && (Mode == S_STEP) && !Halt && StepReq && !step_q;

    always_comb begin
        state_nxt = State;
        if (Halt) begin
            state_nxt = S_HALT;
        end else if (State == S_HALT) begin
            if (Mode == 2'b00 || Mode == 2'b11) begin
                state_nxt = S_IDLE;
            end
        end else begin
            case (Mode)
                2'b01:   state_nxt = S_RUN;
                2'b10:   state_nxt = S_STEP;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clkin) begin
        if (Rst) begin
            State  <= S_IDLE;
            div    <= DIV_RST;
            cnt    <= '0;
            step_q <= 1'b0;
            CpuEn  <= 1'b0;
            Clkout <= 1'b0;
        end else begin
            State  <= state_nxt;
            step_q <= StepReq;
            CpuEn  <= tick | step_fire;
            if (tick) begin
                Clkout <= ~Clkout;
            end
            if (DivLoad) begin
                div <= (DivVal < DIV_MIN) ? DIV_MIN : DivVal;
            end
            // Outside RUN the count is parked at zero so entry to RUN starts a full period.
            if (State != S_RUN || DivLoad || at_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: vector table, hand-written corner sequences, then random traffic against a model.
module tb_cpu_clk_ctrl;
    localparam int CW  = 8;
    localparam int DEF = 4;

    logic          Clkin   = 1'b0;
    logic          Rst     = 1'b1;
    logic [1:0]    Mode    = 2'b00;
    logic          StepReq = 1'b0;
    logic          Halt    = 1'b0;
    logic          DivLoad = 1'b0;
    logic [CW-1:0] DivVal  = '0;
    logic          CpuEn;
    logic          Clkout;
    logic [1:0]    State;

    int tests = 0;
    int fails = 0;

    always #5 Clkin = ~Clkin;

    cpu_clk_ctrl #(.CLK_FREQ(8), .DESIRE_FREQ(2), .CNT_W(CW)) dut (
        .Clkin(Clkin), .Rst(Rst), .Mode(Mode), .StepReq(StepReq), .Halt(Halt),
        .DivLoad(DivLoad), .DivVal(DivVal), .CpuEn(CpuEn), .Clkout(Clkout), .State(State)
    );

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       en;
        logic       ck;
        logic [1:0] st;
    } vec_t;
    vec_t vecs[$];

    // Reference model state: cycles left until the next run enable, rather than a count up.
    int m_st, m_div, m_left, m_clk, m_en, m_prev;

    task automatic cyc();
        @(posedge Clkin);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input int en, input int ck, input int st);
        check({name, "_en"}, CpuEn, en);
        check({name, "_clkout"}, Clkout, ck);
        check({name, "_state"}, State, st);
    endtask

    task automatic add(input logic rst, input logic [1:0] mode, input logic en, input logic ck,
                       input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.mode = mode; v.en = en; v.ck = ck; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        Rst = 1'b1; Mode = 2'b00; StepReq = 1'b0; Halt = 1'b0; DivLoad = 1'b0;
        cyc();
        cyc();
        Rst = 1'b0;
    endtask

    task automatic wait_en(input string name, input int budget);
        int n = 0;
        while (!CpuEn && n < budget) begin
            cyc();
            n++;
        end
        check(name, CpuEn, 1);
    endtask

    // Next n cycles: no enable until the n-th, which must carry one.
    task automatic gap(input string name, input int n);
        for (int i = 1; i <= n; i++) begin
            cyc();
            check(name, CpuEn, (i == n) ? 1 : 0);
        end
    endtask

    task automatic model_edge();
        int ns, nd;
        bit t, sf;
        if (Rst) begin
            m_st = 0; m_div = DEF; m_en = 0; m_clk = 0; m_prev = 0; m_left = 0;
        end else begin
            t  = (m_st == 1) && (m_left == 1) && !DivLoad && !Halt && (Mode == 2'd1);
            sf = (m_st == 2) && (Mode == 2'd2) && !Halt && StepReq && !m_prev;
            if (Halt) ns = 3;
            else if (m_st == 3) ns = (Mode == 2'd1 || Mode == 2'd2) ? 3 : 0;
            else ns = (Mode == 2'd3) ? 0 : int'(Mode);
            nd = DivLoad ? ((DivVal < 2) ? 2 : int'(DivVal)) : m_div;
            if (ns == 1) m_left = (m_st != 1 || DivLoad || m_left == 1) ? nd : m_left - 1;
            m_div  = nd;
            m_en   = (t || sf) ? 1 : 0;
            if (t) m_clk = 1 - m_clk;
            m_prev = StepReq;
            m_st   = ns;
        end
    endtask

    initial begin
        int pulses;
        int r;

        // Reset defaults then continuous run with div=4 and a Mode=11 exit.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1);
        add(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1);
        add(0, 3, 0, 1, 0);
        add(0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            Rst = vecs[i].rst; Mode = vecs[i].mode;
            StepReq = 1'b0; Halt = 1'b0; DivLoad = 1'b0;
            cyc();
            check_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].ck, vecs[i].st);
        end

        // Reload mid-run, then clamp of DivVal=1 to 2.
        do_reset();
        Mode = 2'd1;
        cyc();
        wait_en("reload_first", 10);
        cyc();
        cyc();
        DivLoad = 1'b1; DivVal = CW'(6);
        cyc();
        DivLoad = 1'b0;
        gap("reload6", 6);
        gap("reload6b", 6);
        gap("reload6c", 6);
        DivLoad = 1'b1; DivVal = CW'(1);
        cyc();
        DivLoad = 1'b0;
        gap("clamp", 2);
        gap("clamp_b", 2);
        gap("clamp_c", 2);

        // Single step: held press, separated presses, press outside STEP.
        do_reset();
        Mode = 2'd2;
        cyc();
        StepReq = 1'b1;
        cyc();
        check("step_first", CpuEn, 1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            pulses += CpuEn;
        end
        check("step_hold", pulses, 0);
        StepReq = 1'b0;
        cyc();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            StepReq = 1'b1;
            cyc();
            pulses += CpuEn;
            StepReq = 1'b0;
            cyc();
            pulses += CpuEn;
            cyc();
            pulses += CpuEn;
        end
        check("step_three", pulses, 3);
        Mode = 2'd0;
        cyc();
        StepReq = 1'b1;
        cyc();
        cyc();
        Mode = 2'd2;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            pulses += CpuEn;
        end
        check("step_discard", pulses, 0);
        check("step_state", State, 2);
        StepReq = 1'b0;

        // Halt coinciding with a due tick.
        do_reset();
        Mode = 2'd1;
        cyc();
        wait_en("halt_first", 10);
        cyc();
        cyc();
        cyc();
        Halt = 1'b1;
        cyc();
        check_out("halt_tick", 0, 1, 3);
        Mode = 2'd1;
        cyc();
        check_out("halt_run", 0, 1, 3);
        Mode = 2'd2;
        cyc();
        check("halt_step_st", State, 3);
        Halt = 1'b0; Mode = 2'd1;
        cyc();
        check("halt_keep_run", State, 3);
        Mode = 2'd2;
        cyc();
        check_out("halt_keep_step", 0, 1, 3);
        Mode = 2'd0;
        cyc();
        check("halt_exit", State, 0);
        Halt = 1'b1;
        cyc();
        check("halt_from_idle", State, 3);
        Halt = 1'b0;
        cyc();
        check("halt_idle_again", State, 0);

        // Reset one cycle before a due tick, with a non-default divider loaded.
        do_reset();
        DivLoad = 1'b1; DivVal = CW'(5);
        cyc();
        DivLoad = 1'b0; Mode = 2'd1;
        cyc();
        wait_en("rst_first", 10);
        cyc();
        cyc();
        cyc();
        Rst = 1'b1;
        cyc();
        check_out("rst_mid", 0, 0, 0);
        Rst = 1'b0;
        gap("rst_div", 5);

        // Mode 11 from RUN.
        Mode = 2'd3;
        cyc();
        check("mode11_state", State, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            pulses += CpuEn;
        end
        check("mode11_quiet", pulses, 0);

        // Random traffic against the model.
        Rst = 1'b1; Halt = 1'b0; DivLoad = 1'b0; StepReq = 1'b0;
        model_edge();
        cyc();
        Rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            Mode = (r < 50) ? 2'd1 : (r < 70) ? 2'd2 : (r < 85) ? 2'd0 : 2'd3;
            if ($urandom_range(0, 3) == 0) StepReq = ~StepReq;
            Halt = ($urandom_range(0, 39) == 0);
            if (m_st == 3 && (Mode == 2'd0 || Mode == 2'd3)) Halt = 1'b0;
            DivLoad = ($urandom_range(0, 49) == 0);
            DivVal = CW'($urandom_range(0, 7));
            Rst = ($urandom_range(0, 299) == 0);
            model_edge();
            cyc();
            check("rand_en", CpuEn, m_en);
            check("rand_clkout", Clkout, m_clk);
            check("rand_state", State, m_st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run/step controller that sequences the RISC CPU core from the board clock. It divides `Clkin` into a programmable-rate, one-cycle clock-enable (`CpuEn`) for continuous run, and issues single enables for manual stepping. It latches the CPU's halt indication, and drives a visible 50%-duty `Clkout` for the board LED. It sits between the board clock/switch inputs and the CPU top level; the CPU is clocked by `Clkin` and advances only when `CpuEn` is high.

## Interface
- `CLK_FREQ`, default 100_000_000: `Clkin` frequency in Hz.
- `DESIRE_FREQ`, default 1: reset-time CPU step rate in Hz.
- `CNT_W`, default 27: width of the divide register and counter.
- `Clkin` input 1: single system clock; all logic is on its rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Mode` input 2: 00 idle, 01 run, 10 step, 11 treated as 00.
- `StepReq` input 1: step button level, debounced and synchronised externally.
- `Halt` input 1: CPU halt indication, level.
- `DivLoad` input 1: one-cycle strobe that loads `DivVal`.
- `DivVal` input CNT_W: new divide value, in `Clkin` cycles per `CpuEn`.
- `CpuEn` output 1: registered one-cycle CPU advance enable.
- `Clkout` output 1: registered, toggles on every run tick.
- `State` output 2: registered controller state (encodings under Operation).

## Operation
- **Divide register `div`**
  - Reset value is CLK_FREQ/DESIRE_FREQ, truncated to CNT_W.
  - `DivLoad` loads `DivVal`; values below 2 are clamped to 2.
- **Counter `cnt`** counts 0..div-1, and only while `State`=RUN.
  - `cnt` is forced to 0 on entry to RUN.
  - `cnt` is forced to 0 in any cycle `DivLoad`=1.
  - `cnt` is forced to 0 in every non-RUN state.
- **Tick**: occurs when `State`=RUN, `cnt`=div-1 and `DivLoad`=0.
  - The tick wraps `cnt` to 0.
  - The tick sets `CpuEn`=1 in the next cycle.
  - The tick toggles `Clkout`.
- **States**: IDLE=00, RUN=01, STEP=10, HALTED=11.
- **Halt latch**: `Halt`=1 in any state moves the controller to HALTED. This has priority over `Mode`, ticks and steps.
- **HALTED**:
  - No `CpuEn` is issued.
  - It is left only when `Mode` is 00 or 11, which goes to IDLE.
  - If `Halt` is still 1 while in IDLE, the controller returns to HALTED on the next cycle.
- **IDLE/RUN/STEP**: the next state follows `Mode` each cycle (00/11→IDLE, 01→RUN, 10→STEP).
- **Step edge detect**: `StepReq` is registered into `step_q`; a rise is `StepReq & ~step_q`.
  - In STEP, a rise sampled with `Mode`=10 and `Halt`=0 issues exactly one `CpuEn`.
  - A held `StepReq` never repeats.
  - A rise outside STEP is discarded, not queued.
- **Clkout** holds its value outside RUN.
- **Reset values**: `CpuEn`=0, `Clkout`=0, `State`=IDLE, `cnt`=0, `step_q`=0, `div`=default.
- **Reset mid-operation** abandons any pending tick or step; no `CpuEn` occurs in the cycle after `Rst`.

## Timing
- **Run latency**: `State` becomes RUN at cycle e.
  - First `CpuEn` at cycle e+div, then every div cycles.
  - `Clkout` period is 2·div cycles.
- **Step latency**: rise sampled at cycle t gives `CpuEn`=1 during t+1 only.
- **`CpuEn` width**: exactly one cycle; it is never high in two consecutive cycles (div≥2).
- **`DivLoad` in RUN at cycle t**:
  - A tick due at t is cancelled.
  - New div applies from t+1 with `cnt`=0, so the next `CpuEn` is at t+1+new_div.
- **`Halt` and tick in the same cycle**: no `CpuEn`; `State`=HALTED next cycle; `Clkout` does not toggle.
- **`Mode` change in the same cycle as a tick**: the tick fires only if `Mode`=01 in that cycle.
- **`State` latency**: the output reflects the transition one cycle after the causing input.

## Test plan
- **Reset defaults** (CLK_FREQ=8, DESIRE_FREQ=2 → div=4): hold `Rst` 3 cycles → `CpuEn`=0, `Clkout`=0, `State`=00; release, `Mode`=01 → `CpuEn` pulses every 4 cycles, first 4 cycles after `State`=01; `Clkout` period 8.
- **Reload mid-run**: with div=4, pulse `DivLoad` with `DivVal`=6 two cycles after a `CpuEn` → next `CpuEn` 7 cycles after the strobe, then every 6. `DivVal`=1 → pulses every 2 cycles (clamp).
- **Single step**: `Mode`=10; hold `StepReq` high 10 cycles → exactly one `CpuEn`, 1 cycle after the rise. Three separated presses → 3 pulses. Press while `Mode`=00, then switch to 10 → 0 pulses.
- **Halt while running**: in RUN, assert `Halt` in the same cycle `cnt`=div-1 → no `CpuEn`, `State`=11 next cycle, `Clkout` frozen. `Mode`=01 or 10 keeps HALTED. Deassert `Halt` and set `Mode`=00 → IDLE.
- **Mid-operation reset**: assert `Rst` one cycle before a due tick in RUN → no `CpuEn`; `State`=00, `Clkout`=0, div restored to 4.
- **Mode 11**: drive `Mode`=11 from RUN → `State`=00 next cycle; no `CpuEn` for 20 cycles.
